// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: 8-digit scanned BCD display of sum/candy_sum; SEG_LZ_SUPPRESS_EN blanks leading zeros
module seven_seg_scan_ctrl #(
  parameter int CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sum,
  input  logic [2:0] candy_sum,
  input  logic       load,
  output logic [7:0] display_column,
  output logic [3:0] data_out,
  output logic       busy
);
  localparam int PW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  state_t state, state_nx;
  logic [PW-1:0] presc;
  logic [2:0] idx, cnt, candy_q, candy_s;
  logic [7:0] bin_q;
  logic [11:0] bcd, bcd_adj;
  logic [3:0] hun_s, ten_s, one_s, hun_d, ten_d;
  logic blank;
  function automatic logic [3:0] adj(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      presc <= '0;
      idx <= '0;
    end else begin
      presc <= presc == PW'(CLK_DIV - 1) ? '0 : presc + 1'b1;
      idx <= presc == PW'(CLK_DIV - 1) ? idx + 3'd1 : idx;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = load ? CONV : IDLE;
      CONV:    state_nx = cnt == 3'd7 ? COMMIT : CONV;
      default: state_nx = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign bcd_adj = {adj(bcd[11:8]), adj(bcd[7:4]), adj(bcd[3:0])};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bin_q <= '0;
      candy_q <= '0;
      bcd <= '0;
      cnt <= '0;
      hun_s <= '0;
      ten_s <= '0;
      one_s <= '0;
      candy_s <= '0;
    end else if (state == IDLE && load) begin
      bin_q <= sum;
      candy_q <= candy_sum;
      bcd <= '0;
      cnt <= '0;
    end else if (state == CONV) begin
      {bcd, bin_q} <= {bcd_adj[10:0], bin_q, 1'b0};
      cnt <= cnt + 3'd1;
    end else if (state == COMMIT) begin
      hun_s <= bcd[11:8];
      ten_s <= bcd[7:4];
      one_s <= bcd[3:0];
      candy_s <= candy_q;
    end
`ifdef SEG_LZ_SUPPRESS_EN
  assign hun_d = hun_s == 4'd0 ? 4'hF : hun_s;
  assign ten_d = (hun_s == 4'd0 && ten_s == 4'd0) ? 4'hF : ten_s;
`else
  assign hun_d = hun_s;
  assign ten_d = ten_s;
`endif
  // prescaler==0 is a one-cycle all-off gap between digits to avoid ghosting
  assign blank = presc == '0;
  assign display_column = blank ? 8'hFF : ~(8'd1 << idx);
  always_comb
    data_out = blank       ? 4'hF :
               idx == 3'd0 ? one_s :
               idx == 3'd1 ? ten_d :
               idx == 3'd2 ? hun_d :
               idx == 3'd4 ? {1'b0, candy_s} : 4'hF;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed scoreboard bench for seven_seg_scan_ctrl with CLK_DIV=4
module tb_seven_seg_scan_ctrl;
  logic clk = 0, rst_n = 0, load = 0;
  logic [7:0] sum = 0;
  logic [2:0] candy_sum = 0;
  logic [7:0] display_column;
  logic [3:0] data_out;
  logic busy;
  int errors = 0, checks = 0;
  typedef struct {logic [7:0] s; logic [2:0] c;} exp_t;
  exp_t sb[$];

  seven_seg_scan_ctrl #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(rst_n), .sum(sum), .candy_sum(candy_sum), .load(load),
    .display_column(display_column), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_digit(input int i, input logic [7:0] s, input logic [2:0] c);
    int h, t, o;
    h = s / 100; t = (s / 10) % 10; o = s % 10;
    case (i)
      0: return 4'(o);
`ifdef SEG_LZ_SUPPRESS_EN
      1: return (h == 0 && t == 0) ? 4'hF : 4'(t);
      2: return h == 0 ? 4'hF : 4'(h);
`else
      1: return 4'(t);
      2: return 4'(h);
`endif
      4: return {1'b0, c};
      default: return 4'hF;
    endcase
  endfunction

  task automatic read_digit(input int i, input logic [3:0] e, input string tag);
    logic [7:0] tgt;
    int n = 0;
    tgt = ~(8'd1 << i);
    while (display_column !== tgt && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_col"}, display_column, tgt);
    check(tag, data_out, e);
  endtask

  task automatic do_load(input logic [7:0] s, input logic [2:0] c, input bit push);
    exp_t x;
    @(negedge clk);
    sum = s; candy_sum = c; load = 1;
    @(negedge clk);
    load = 0;
    x.s = s; x.c = c;
    if (push) sb.push_back(x);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_digits(input string tag);
    exp_t x;
    check({tag, "_sb"}, sb.size(), 1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      read_digit(0, model_digit(0, x.s, x.c), {tag, "_d0"});
      read_digit(1, model_digit(1, x.s, x.c), {tag, "_d1"});
      read_digit(2, model_digit(2, x.s, x.c), {tag, "_d2"});
      read_digit(4, model_digit(4, x.s, x.c), {tag, "_d4"});
    end
  endtask

  initial begin
    int n, p, ix, hi;
    logic [7:0] ec;
    logic [3:0] ed;
    #12;
    check("rst_col", display_column, 8'hFF);
    check("rst_data", data_out, 4'hF);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    p = 0; ix = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (p == 3) begin p = 0; ix = (ix + 1) % 8; end else p++;
      ec = p == 0 ? 8'hFF : ~(8'd1 << ix);
      ed = p == 0 ? 4'hF : model_digit(ix, 8'd0, 3'd0);
      check($sformatf("scan_col_%0d", k), display_column, ec);
      check($sformatf("scan_data_%0d", k), data_out, ed);
    end
    do_load(8'd255, 3'd0, 1);
    count_busy(n);
    check("busy_255", n, 9);
    check_digits("s255");
    do_load(8'd7, 3'd0, 1);
    count_busy(n);
    check("busy_7", n, 9);
    check_digits("s7");
    do_load(8'd100, 3'd0, 1);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 3) begin sum = 8'd42; load = 1; end else load = 0;
      @(negedge clk);
    end
    load = 0;
    check("busy_100", n, 9);
    repeat (3) @(negedge clk);
    check("idle_after_ignored", busy, 0);
    check_digits("s100");
    do_load(8'd123, 3'd5, 1);
    count_busy(n);
    check_digits("c5");
    do_load(8'd0, 3'd0, 1);
    count_busy(n);
    check_digits("c0");
    do_load(8'd99, 3'd6, 0);
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    check("abort_col", display_column, 8'hFF);
    check("abort_data", data_out, 4'hF);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rel_col", display_column, 8'hFE);
    check("rel_data", data_out, 4'h0);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy) hi++;
      @(negedge clk);
    end
    check("abort_no_busy", hi, 0);
    read_digit(0, model_digit(0, 8'd0, 3'd0), "abort_d0");
    read_digit(1, model_digit(1, 8'd0, 3'd0), "abort_d1");
    read_digit(2, model_digit(2, 8'd0, 3'd0), "abort_d2");
    read_digit(4, model_digit(4, 8'd0, 3'd0), "abort_d4");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 50000: clk cycles per digit slot (legal range 4..2^20).
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port sum  input  8  binary credit value to display.
REQ-005 SHALL provide port candy_sum  input  3  binary candy count to display.
REQ-006 SHALL provide port load  input  1  one-cycle request to capture sum/candy_sum and refresh the display.
REQ-007 SHALL provide port display_column  output  8  digit enable, active-low, at most one bit low.
REQ-008 SHALL provide port data_out  output  4  BCD code for the enabled digit; 4'hF = blank.
REQ-009 SHALL provide port busy  output  1  high while a conversion is in progress.

Function
REQ-010 Prescaler SHALL count 0..CLK_DIV-1 and wrap; digit index (0..7) SHALL advance by one, wrapping 7->0, on the cycle the prescaler wraps.
REQ-011 display_column SHALL be 8'hFF while prescaler==0 (one-cycle anti-ghost blank); otherwise only bit [index] SHALL be low.
REQ-012 data_out mapping by index: 0 = ones(sum), 1 = tens(sum), 2 = hundreds(sum), 3 = 4'hF, 4 = candy_sum zero-extended, 5..7 = 4'hF; data_out SHALL be 4'hF while display_column==8'hFF.
REQ-013 Control FSM states: IDLE, CONV, COMMIT; busy SHALL equal (state != IDLE).
REQ-014 IDLE->CONV on load==1: sum and candy_sum SHALL be captured at that edge; BCD scratch cleared.
REQ-015 CONV SHALL perform sequential double-dabble (add 3 to any BCD nibble >=5, then shift left one bit) for exactly 8 cycles, then go to COMMIT.
REQ-016 COMMIT SHALL, in one cycle, copy hundreds/tens/ones and captured candy_sum into display shadow registers, then return to IDLE.
REQ-017 Latency: load sampled at edge N -> busy high from N to N+9 inclusive edges' outputs (9 cycles), shadow updated at edge N+9, new digits visible from cycle N+9 on.
REQ-018 load while busy==1 SHALL be ignored (no recapture, no restart).
REQ-019 Scanning SHALL be independent of the FSM; shadow registers SHALL change only in COMMIT, so displayed digits never show intermediate conversion values.
REQ-020 Hundreds digit SHALL be 0..2, tens and ones 0..9, for every sum in 0..255.

Reset
REQ-021 On reset low, asynchronously: display_column=8'hFF, data_out=4'hF, busy=0, state=IDLE, prescaler=0, index=0, shadow digits and candy value=0, scratch=0.
REQ-022 Reset asserted mid-conversion SHALL abort it; shadow SHALL hold 0 and no COMMIT SHALL occur after release.
REQ-023 After reset release, first enabled digit SHALL be index 0 at prescaler==1, showing 4'h0.

Configuration
REQ-024 Macro SEG_LZ_SUPPRESS_EN: when defined, hundreds digit SHALL display 4'hF if it is 0, and tens digit SHALL display 4'hF if hundreds and tens are both 0; ones and candy digit never suppressed.
REQ-025 When SEG_LZ_SUPPRESS_EN is undefined, all three sum digits SHALL display their BCD value, including leading zeros.

Verification
REQ-026 sum=255, candy_sum=0, pulse load -> busy high 9 cycles; then index0=4'h5, index1=4'h5, index2=4'h2.
REQ-027 CLK_DIV=4, no load -> display_column sequence per slot: 8'hFF, then 8'hFE x3; after index 7 (8'h7F) wraps to 8'hFE; index3/5..7 data_out=4'hF.
REQ-028 sum=7 with SEG_LZ_SUPPRESS_EN -> index0=4'h7, index1=4'hF, index2=4'hF; without macro -> 4'h7, 4'h0, 4'h0.
REQ-029 load(sum=100), second load(sum=42) 3 cycles later -> second ignored; display shows 1,0,0; busy total 9 cycles.
REQ-030 load(sum=99), reset low at cycle 4 of CONV -> all outputs at reset values; after release index0..2 show 0,0,0, busy stays 0.
REQ-031 candy_sum=5, load -> index4 data_out=4'h5 after COMMIT; candy_sum=0 -> 4'h0 (not blanked).
